// File: rtl/cmp_pkg.sv
// +----------------------------------------------------------------------------+
// | cmp_pkg : shared constants for the comparator operand loader               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package cmp_pkg;

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_HAVE_A = 2'd1;
  localparam logic [1:0] ST_HAVE_B = 2'd2;
  localparam logic [1:0] ST_READY  = 2'd3;

  localparam int DEB_10MS_50MHZ = 500000;

endpackage : cmp_pkg

`default_nettype wire

// File: rtl/btn_debounce.sv
// +----------------------------------------------------------------------------+
// | btn_debounce : active-low push-button synchronizer, debouncer, press pulse |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module btn_debounce
  import cmp_pkg::*;
#(
  parameter int p_DEBOUNCE = DEB_10MS_50MHZ,
  parameter int p_CNT_W    = 19
) (
  input  logic CLOCK_50,
  input  logic RESET,
  input  logic i_btn_n,
  output logic o_stable,
  output logic o_press
);

  localparam logic [p_CNT_W-1:0] c_LAST = p_CNT_W'(p_DEBOUNCE - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_stable;
  logic               r_stable_d;
  logic               r_armed;
  logic               r_press;
  logic [p_CNT_W-1:0] r_cnt;
  logic [p_CNT_W-1:0] r_arm_cnt;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_stable   <= 1'b1;
      r_stable_d <= 1'b1;
      r_cnt      <= '0;
      r_arm_cnt  <= '0;
      r_armed    <= 1'b0;
      r_press    <= 1'b0;
    end else begin
      r_sync1    <= i_btn_n;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      r_press    <= r_stable_d & ~r_stable & r_armed;

      if (r_sync2 != r_stable) begin
        if (r_cnt == c_LAST) begin
          r_stable <= r_sync2;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end

      // A button held through reset must be released before it may fire:
      // arm on a debounced release edge, or after a full debounce window of
      // confirmed release following reset.
      if (r_stable_d && !r_stable) begin
        r_armed   <= 1'b0;
        r_arm_cnt <= '0;
      end else if (r_stable && !r_stable_d) begin
        r_armed <= 1'b1;
      end else if (r_stable && r_sync2 && !r_armed) begin
        if (r_arm_cnt == c_LAST) begin
          r_armed <= 1'b1;
        end else begin
          r_arm_cnt <= r_arm_cnt + 1'b1;
        end
      end else begin
        r_arm_cnt <= '0;
      end
    end
  end

  assign o_stable = r_stable;
  assign o_press  = r_press;

endmodule : btn_debounce

`default_nettype wire

// File: rtl/cmp_operand_loader.sv
// +----------------------------------------------------------------------------+
// | cmp_operand_loader : latches switch operands A/B for the comparator        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module cmp_operand_loader
  import cmp_pkg::*;
#(
  parameter int p_WIDTH    = 5,
  parameter int p_DEBOUNCE = DEB_10MS_50MHZ,
  parameter int p_CNT_W    = 19
) (
  input  logic               CLOCK_50,
  input  logic               RESET,
  input  logic [p_WIDTH-1:0] i_sw,
  input  logic               i_load_a_n,
  input  logic               i_load_b_n,
  input  logic               i_clear_n,
  output logic [p_WIDTH-1:0] o_a,
  output logic [p_WIDTH-1:0] o_b,
  output logic               o_valid,
  output logic               o_update,
  output logic [1:0]         o_state
);

  logic [p_WIDTH-1:0] r_sw_s1;
  logic [p_WIDTH-1:0] r_sw_s2;
  logic [p_WIDTH-1:0] r_a;
  logic [p_WIDTH-1:0] r_b;
  logic [1:0]         r_state;
  logic               r_valid;
  logic               r_update;

  logic               w_press_a;
  logic               w_press_b;
  logic               w_press_clr;
  logic [p_WIDTH-1:0] w_next_a;
  logic [p_WIDTH-1:0] w_next_b;
  logic [1:0]         w_next_state;

  btn_debounce #(.p_DEBOUNCE(p_DEBOUNCE), .p_CNT_W(p_CNT_W)) u_deb_a (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .i_btn_n  (i_load_a_n),
    .o_stable (),
    .o_press  (w_press_a)
  );

  btn_debounce #(.p_DEBOUNCE(p_DEBOUNCE), .p_CNT_W(p_CNT_W)) u_deb_b (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .i_btn_n  (i_load_b_n),
    .o_stable (),
    .o_press  (w_press_b)
  );

  btn_debounce #(.p_DEBOUNCE(p_DEBOUNCE), .p_CNT_W(p_CNT_W)) u_deb_clr (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .i_btn_n  (i_clear_n),
    .o_stable (),
    .o_press  (w_press_clr)
  );

  // Clear overrides any load arriving in the same cycle.
  always_comb begin
    w_next_a     = r_a;
    w_next_b     = r_b;
    w_next_state = r_state;
    if (w_press_clr) begin
      w_next_a     = '0;
      w_next_b     = '0;
      w_next_state = ST_EMPTY;
    end else begin
      if (w_press_a) w_next_a = r_sw_s2;
      if (w_press_b) w_next_b = r_sw_s2;
      if (w_press_a && w_press_b) begin
        w_next_state = ST_READY;
      end else if (w_press_a) begin
        case (r_state)
          ST_EMPTY:  w_next_state = ST_HAVE_A;
          ST_HAVE_B: w_next_state = ST_READY;
          default:   w_next_state = r_state;
        endcase
      end else if (w_press_b) begin
        case (r_state)
          ST_EMPTY:  w_next_state = ST_HAVE_B;
          ST_HAVE_A: w_next_state = ST_READY;
          default:   w_next_state = r_state;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_state  <= ST_EMPTY;
      r_valid  <= 1'b0;
      r_update <= 1'b0;
    end else begin
      r_sw_s1  <= i_sw;
      r_sw_s2  <= r_sw_s1;
      r_a      <= w_next_a;
      r_b      <= w_next_b;
      r_state  <= w_next_state;
      r_valid  <= (w_next_state == ST_READY);
      r_update <= w_press_a | w_press_b | w_press_clr;
    end
  end

  assign o_a      = r_a;
  assign o_b      = r_b;
  assign o_valid  = r_valid;
  assign o_update = r_update;
  assign o_state  = r_state;

endmodule : cmp_operand_loader

`default_nettype wire

// File: tb/tb_cmp_operand_loader.sv
// +----------------------------------------------------------------------------+
// | tb_cmp_operand_loader : directed scoreboard bench for cmp_operand_loader   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cmp_operand_loader;

  logic       CLOCK_50 = 1'b0;
  logic       RESET;
  logic [4:0] i_sw;
  logic       i_load_a_n;
  logic       i_load_b_n;
  logic       i_clear_n;
  logic [4:0] o_a;
  logic [4:0] o_b;
  logic       o_valid;
  logic       o_update;
  logic [1:0] o_state;

  typedef struct packed {
    logic [4:0] a;
    logic [4:0] b;
    logic [1:0] st;
    logic       v;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   upd_count  = 0;
  int   u0;

  cmp_operand_loader #(.p_WIDTH(5), .p_DEBOUNCE(4), .p_CNT_W(3)) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET      (RESET),
    .i_sw       (i_sw),
    .i_load_a_n (i_load_a_n),
    .i_load_b_n (i_load_b_n),
    .i_clear_n  (i_clear_n),
    .o_a        (o_a),
    .o_b        (o_b),
    .o_valid    (o_valid),
    .o_update   (o_update),
    .o_state    (o_state)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Counts every update pulse so unexpected ones are caught between checks.
  always @(posedge CLOCK_50) begin
    #2;
    if (o_update === 1'b1) upd_count++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wait_update(input string tag, input int budget);
    bit   seen;
    exp_t e;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLOCK_50);
      if (o_update === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      if (sb.size() == 0) begin
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk(tag, 32'({o_a, o_b, o_state, o_valid}), 32'(e));
      end
      @(negedge CLOCK_50);
      chk({tag, "_one_cycle"}, 32'(o_update), 32'd0);
    end
    @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    RESET      = 1'b1;
    i_sw       = 5'h00;
    i_load_a_n = 1'b1;
    i_load_b_n = 1'b1;
    i_clear_n  = 1'b1;
    step(3);
    RESET = 1'b0;

    // 1: idle after reset
    step(20);
    @(negedge CLOCK_50);
    chk("rst_a", 32'(o_a), 32'h0);
    chk("rst_b", 32'(o_b), 32'h0);
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_state", 32'(o_state), 32'h0);
    chk("rst_no_update", 32'(upd_count), 32'd0);
    step(1);

    // 2: load A with exact latency, then B
    i_sw = 5'h13;
    sb.push_back('{a: 5'h13, b: 5'h00, st: 2'd1, v: 1'b0});
    i_load_a_n = 1'b0;
    repeat (7) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("lat_a_early", 32'(o_update), 32'd0);
    wait_update("load_a", 1);
    step(1);
    i_load_a_n = 1'b1;
    step(15);
    i_sw = 5'h07;
    sb.push_back('{a: 5'h13, b: 5'h07, st: 2'd3, v: 1'b1});
    i_load_b_n = 1'b0;
    wait_update("load_b", 40);
    step(2);
    i_load_b_n = 1'b1;
    step(15);

    // 3: bounce shorter than the debounce window
    u0   = upd_count;
    i_sw = 5'h1A;
    for (int i = 0; i < 5; i++) begin
      i_load_a_n = 1'b0;
      step(3);
      i_load_a_n = 1'b1;
      step(1);
    end
    step(15);
    @(negedge CLOCK_50);
    chk("bounce_a", 32'(o_a), 32'h13);
    chk("bounce_no_update", 32'(upd_count), 32'(u0));
    step(1);

    // 4: clear, then simultaneous A+B from EMPTY
    sb.push_back('{a: 5'h00, b: 5'h00, st: 2'd0, v: 1'b0});
    i_clear_n = 1'b0;
    wait_update("clear", 40);
    i_clear_n = 1'b1;
    step(15);
    u0   = upd_count;
    i_sw = 5'h1F;
    sb.push_back('{a: 5'h1F, b: 5'h1F, st: 2'd3, v: 1'b1});
    i_load_a_n = 1'b0;
    i_load_b_n = 1'b0;
    wait_update("load_ab", 40);
    step(10);
    chk("ab_single_update", 32'(upd_count), 32'(u0 + 1));
    i_load_a_n = 1'b1;
    i_load_b_n = 1'b1;
    step(15);

    // 5: clear beats load_a in the same cycle
    u0   = upd_count;
    i_sw = 5'h0C;
    sb.push_back('{a: 5'h00, b: 5'h00, st: 2'd0, v: 1'b0});
    i_clear_n  = 1'b0;
    i_load_a_n = 1'b0;
    wait_update("clear_wins", 40);
    i_clear_n  = 1'b1;
    i_load_a_n = 1'b1;
    step(15);
    chk("clr_single_update", 32'(upd_count), 32'(u0 + 1));

    // 6: reset while B held, then fresh press
    i_sw = 5'h0A;
    i_load_b_n = 1'b0;
    step(2);
    RESET = 1'b1;
    step(2);
    RESET = 1'b0;
    u0 = upd_count;
    step(20);
    @(negedge CLOCK_50);
    chk("held_no_update", 32'(upd_count), 32'(u0));
    chk("held_b", 32'(o_b), 32'h0);
    chk("held_state", 32'(o_state), 32'h0);
    step(1);
    i_load_b_n = 1'b1;
    step(15);
    sb.push_back('{a: 5'h00, b: 5'h0A, st: 2'd2, v: 1'b0});
    i_load_b_n = 1'b0;
    wait_update("fresh_b", 40);
    i_load_b_n = 1'b1;
    step(15);
    chk("fresh_single_update", 32'(upd_count), 32'(u0 + 1));
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_cmp_operand_loader

`default_nettype wire
